// File: rtl/tl_tx_err_msg_transmitter.sv
// ---------------------------------------------------------------------------
// tl_tx_err_msg_transmitter
//
// TX-side consumer of the RX error-handler FIFO. It takes one pending entry
// at a time. Each entry is either an error message (4DW header) or an
// Unsupported Request completion (3DW header). For each entry it:
//   - waits for the matching header credit,
//   - arbitrates for the TX TLP path,
//   - serialises the header one DW per beat using a valid/ready handshake,
//   - reports the consumed credit to TX flow control.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-low reset
//   i_empty_flag            error FIFO empty
//   i_tlp_msg               FIFO head entry (DW0 in the top bits)
//   i_ur_cpl_valid          head entry is a UR completion (1) or a message (0)
//   o_msg_trans_en          enables the FIFO head output
//   o_read_ptr_incr         one-cycle FIFO pop pulse
//   i_ph_credit_avail       posted-header credit available
//   i_cplh_credit_avail     completion-header credit available
//   o_ph_consume            one-cycle pulse: one posted-header credit used
//   o_cplh_consume          one-cycle pulse: one completion-header credit used
//   o_arb_req, i_arb_grant  TX arbiter request / grant
//   o_tlp_data              header DW of the current beat
//   o_tlp_valid             beat valid
//   i_tlp_ready             downstream accepts the beat
//   o_sop, o_eop            first / last beat of the TLP
//   o_busy                  engine is handling an entry
//   o_sent_cnt              saturating count of fully transmitted TLPs
// ---------------------------------------------------------------------------
module tl_tx_err_msg_transmitter #(
    parameter int MSG_WIDTH = 128,
    parameter int DW_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_empty_flag,
    input  logic [MSG_WIDTH-1:0] i_tlp_msg,
    input  logic                 i_ur_cpl_valid,
    output logic                 o_msg_trans_en,
    output logic                 o_read_ptr_incr,
    input  logic                 i_ph_credit_avail,
    input  logic                 i_cplh_credit_avail,
    output logic                 o_ph_consume,
    output logic                 o_cplh_consume,
    output logic                 o_arb_req,
    input  logic                 i_arb_grant,
    output logic [DW_WIDTH-1:0]  o_tlp_data,
    output logic                 o_tlp_valid,
    input  logic                 i_tlp_ready,
    output logic                 o_sop,
    output logic                 o_eop,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_sent_cnt
);

    localparam int NUM_DW = MSG_WIDTH / DW_WIDTH;
    localparam int IDX_W  = (NUM_DW > 1) ? $clog2(NUM_DW) : 1;

    // An error message carries a 4DW header, a UR completion a 3DW header.
    localparam logic [IDX_W-1:0] MSG_LAST_IDX = IDX_W'(3);
    localparam logic [IDX_W-1:0] CPL_LAST_IDX = IDX_W'(2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_CRED,
        REQ,
        SEND
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [MSG_WIDTH-1:0] hdr_reg;
    logic                 is_cpl;
    logic [IDX_W-1:0]     beat_idx;
    logic [IDX_W-1:0]     last_idx;
    logic                 credit_ok;
    logic                 beat_fire;
    logic                 pkt_done;

    assign last_idx  = is_cpl ? CPL_LAST_IDX : MSG_LAST_IDX;
    assign credit_ok = is_cpl ? i_cplh_credit_avail : i_ph_credit_avail;
    assign beat_fire = (state_q == SEND) && i_tlp_ready;
    assign pkt_done  = beat_fire && (beat_idx == last_idx);

    // State register. Reset drops any half-sent entry: the FIFO pop already
    // happened, so the packet is simply lost and no credit is reported.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The grant is only sampled in REQ; once in SEND the
    // arbiter is expected to hold it, so a grant drop there is ignored.
    // Credits are likewise only sampled in WAIT_CRED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!i_empty_flag) state_d = LOAD;
            LOAD:      state_d = WAIT_CRED;
            WAIT_CRED: if (credit_ok) state_d = REQ;
            REQ:       if (i_arb_grant) state_d = SEND;
            SEND:      if (pkt_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Header capture happens in the single LOAD cycle, which is the only
    // cycle in which the FIFO presents its head entry.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hdr_reg <= '0;
            is_cpl  <= 1'b0;
        end else if (state_q == LOAD) begin
            hdr_reg <= i_tlp_msg;
            is_cpl  <= i_ur_cpl_valid;
        end
    end

    // Beat index: restarts at the grant and only moves on an accepted beat,
    // so data, sop and eop hold still under backpressure.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            beat_idx <= '0;
        end else if (state_q == REQ) begin
            beat_idx <= '0;
        end else if (beat_fire && !pkt_done) begin
            beat_idx <= beat_idx + IDX_W'(1);
        end
    end

    // Sent-packet statistics, saturating at all-ones.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_sent_cnt <= '0;
        end else if (pkt_done && (o_sent_cnt != '1)) begin
            o_sent_cnt <= o_sent_cnt + CNT_WIDTH'(1);
        end
    end

    // DW selection: DW0 lives in the most significant bits of the entry.
    always_comb begin
        o_tlp_data = '0;
        if (state_q == SEND) begin
            for (int i = 0; i < NUM_DW; i++) begin
                if (beat_idx == IDX_W'(i)) begin
                    o_tlp_data = hdr_reg[MSG_WIDTH-1-i*DW_WIDTH -: DW_WIDTH];
                end
            end
        end
    end

    // Control outputs are decoded from the state so that an asynchronous
    // reset forces them all low without waiting for a clock edge.
    always_comb begin
        o_msg_trans_en  = 1'b0;
        o_read_ptr_incr = 1'b0;
        o_arb_req       = 1'b0;
        o_tlp_valid     = 1'b0;
        o_sop           = 1'b0;
        o_eop           = 1'b0;
        o_ph_consume    = 1'b0;
        o_cplh_consume  = 1'b0;
        case (state_q)
            LOAD: begin
                o_msg_trans_en  = 1'b1;
                o_read_ptr_incr = 1'b1;
            end
            REQ: begin
                o_arb_req = 1'b1;
            end
            SEND: begin
                o_arb_req      = 1'b1;
                o_tlp_valid    = 1'b1;
                o_sop          = (beat_idx == '0);
                o_eop          = (beat_idx == last_idx);
                o_ph_consume   = pkt_done && !is_cpl;
                o_cplh_consume = pkt_done && is_cpl;
            end
            default: begin
            end
        endcase
    end

    assign o_busy = (state_q != IDLE);

endmodule
